// File: rtl/bmu_modport.sv
// Single-cycle bit-manipulation / ALU execute unit driven by a one-hot op packet.
// Optional grev/gorc permutation ops are built only when BMU_ZBP_EN is defined.
module bmu_modport (
    input  logic        clk,
    input  logic        rstL,
    input  logic        scanMode,
    input  logic        validIn,
    input  logic [41:0] ap,
    input  logic        csrRenIn,
    input  logic [31:0] csrRdataIn,
    input  logic [31:0] aIn,
    input  logic [31:0] bIn,
    output logic [31:0] resultFf,
    output logic        error
);
    localparam int CLZ = 41, CTZ = 40, CPOP = 39, SIEXT_B = 38, SIEXT_H = 37;
    localparam int MIN = 36, MAX = 35, PACK = 34, PACKU = 33, PACKH = 32;
    localparam int ROL = 31, ROR = 30, GREV = 29, GORC = 28, ZBB = 27;
    localparam int BSET = 26, BCLR = 25, BINV = 24, BEXT = 23;
    localparam int SH1ADD = 22, SH2ADD = 21, SH3ADD = 20, ZBA = 19;
    localparam int LAND = 18, LOR = 17, LXOR = 16, SLL = 15, SRL = 14, SRA = 13;
    localparam int BEQ = 12, BNE = 11, BLT = 10, BGE = 9, ADD = 8, SUB = 7;
    localparam int SLT = 6, UNSIGN = 5, JAL = 4, PREDICT_T = 3, PREDICT_NT = 2;
    localparam int CSR_WRITE = 1, CSR_IMM = 0;

    // Modifier bits qualify an operation but never select one on their own.
    localparam logic [41:0] MOD_MASK = (42'd1 << ZBB) | (42'd1 << ZBA) | (42'd1 << UNSIGN)
                                     | (42'd1 << PREDICT_T) | (42'd1 << PREDICT_NT)
                                     | (42'd1 << CSR_IMM);

    logic [42:0] sel;
    logic        one_hot;
    logic        shadd_no_zba;
    logic        zbp_illegal;
    logic        illegal;
    logic [4:0]  sh;
    logic        lt;
    logic [63:0] rot_l;
    logic [63:0] rot_r;
    logic [31:0] result_d;
    logic        unused_scan;

    assign unused_scan  = scanMode;
    assign sel          = {ap & ~MOD_MASK, csrRenIn};
    assign one_hot      = (sel != '0) && ((sel & (sel - 43'd1)) == '0);
    assign shadd_no_zba = (ap[SH1ADD] | ap[SH2ADD] | ap[SH3ADD]) & ~ap[ZBA];
    assign sh           = bIn[4:0];
    assign lt           = ap[UNSIGN] ? (aIn < bIn) : ($signed(aIn) < $signed(bIn));
    assign rot_l        = {aIn, aIn} << sh;
    assign rot_r        = {aIn, aIn} >> sh;

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] ctz32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n = 6'd32;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!found && v[i]) begin
                n = 6'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] cpop32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

`ifdef BMU_ZBP_EN
    // Each stage k swaps (grev) or swap-ORs (gorc) adjacent 2^k-bit groups when sh[k] is set.
    function automatic logic [31:0] perm32(input logic [31:0] v, input logic [4:0] s,
                                           input logic or_mode);
        logic [31:0] x;
        logic [31:0] swapped;
        logic [31:0] masks [5];
        masks = '{32'h5555_5555, 32'h3333_3333, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0000_FFFF};
        x = v;
        for (int k = 0; k < 5; k++) begin
            if (s[k]) begin
                swapped = ((x & masks[k]) << (1 << k)) | ((x >> (1 << k)) & masks[k]);
                x = or_mode ? (x | swapped) : swapped;
            end
        end
        return x;
    endfunction

    assign zbp_illegal = 1'b0;
`else
    assign zbp_illegal = ap[GREV] | ap[GORC];
`endif

    assign illegal = ~one_hot | shadd_no_zba | zbp_illegal;

    // Result mux; only meaningful when exactly one select is set, otherwise masked by illegal.
    always_comb begin
        result_d = '0;
        if (csrRenIn)          result_d = csrRdataIn;
        else if (ap[ADD])      result_d = aIn + bIn;
        else if (ap[SUB])      result_d = aIn - bIn;
        else if (ap[SLT])      result_d = {31'b0, lt};
        else if (ap[LAND])     result_d = ap[ZBB] ? (aIn & ~bIn) : (aIn & bIn);
        else if (ap[LOR])      result_d = ap[ZBB] ? (aIn | ~bIn) : (aIn | bIn);
        else if (ap[LXOR])     result_d = ap[ZBB] ? ~(aIn ^ bIn) : (aIn ^ bIn);
        else if (ap[SLL])      result_d = aIn << sh;
        else if (ap[SRL])      result_d = aIn >> sh;
        else if (ap[SRA])      result_d = 32'($signed(aIn) >>> sh);
        else if (ap[ROL])      result_d = rot_l[63:32];
        else if (ap[ROR])      result_d = rot_r[31:0];
        else if (ap[SH1ADD])   result_d = (aIn << 1) + bIn;
        else if (ap[SH2ADD])   result_d = (aIn << 2) + bIn;
        else if (ap[SH3ADD])   result_d = (aIn << 3) + bIn;
        else if (ap[CLZ])      result_d = {26'b0, clz32(aIn)};
        else if (ap[CTZ])      result_d = {26'b0, ctz32(aIn)};
        else if (ap[CPOP])     result_d = {26'b0, cpop32(aIn)};
        else if (ap[SIEXT_B])  result_d = {{24{aIn[7]}}, aIn[7:0]};
        else if (ap[SIEXT_H])  result_d = {{16{aIn[15]}}, aIn[15:0]};
        else if (ap[MIN])      result_d = lt ? aIn : bIn;
        else if (ap[MAX])      result_d = lt ? bIn : aIn;
        else if (ap[PACK])     result_d = {bIn[15:0], aIn[15:0]};
        else if (ap[PACKU])    result_d = {bIn[31:16], aIn[31:16]};
        else if (ap[PACKH])    result_d = {16'b0, bIn[7:0], aIn[7:0]};
        else if (ap[BSET])     result_d = aIn | (32'd1 << sh);
        else if (ap[BCLR])     result_d = aIn & ~(32'd1 << sh);
        else if (ap[BINV])     result_d = aIn ^ (32'd1 << sh);
        else if (ap[BEXT])     result_d = {31'b0, aIn[sh]};
        else if (ap[BEQ])      result_d = {31'b0, aIn == bIn};
        else if (ap[BNE])      result_d = {31'b0, aIn != bIn};
        else if (ap[BLT])      result_d = {31'b0, lt};
        else if (ap[BGE])      result_d = {31'b0, ~lt};
        else if (ap[JAL])      result_d = aIn + 32'd4;
        else if (ap[CSR_WRITE]) result_d = ap[CSR_IMM] ? bIn : aIn;
`ifdef BMU_ZBP_EN
        else if (ap[GREV])     result_d = perm32(aIn, sh, 1'b0);
        else if (ap[GORC])     result_d = perm32(aIn, sh, 1'b1);
`endif
    end

    // Idle cycles keep the last result but never a stale error.
    always_ff @(posedge clk) begin
        if (!rstL) begin
            resultFf <= '0;
            error    <= 1'b0;
        end else if (validIn) begin
            resultFf <= illegal ? 32'd0 : result_d;
            error    <= illegal;
        end else begin
            error    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bmu_modport.sv
// Randomized self-checking bench for bmu_modport against an operation-level reference model.
// Expectations for grev/gorc follow BMU_ZBP_EN the same way the design does.
module tb_bmu_modport;
    localparam int CLZ = 41, CTZ = 40, CPOP = 39, SIEXT_B = 38, SIEXT_H = 37;
    localparam int MIN = 36, MAX = 35, PACK = 34, PACKU = 33, PACKH = 32;
    localparam int ROL = 31, ROR = 30, GREV = 29, GORC = 28, ZBB = 27;
    localparam int BSET = 26, BCLR = 25, BINV = 24, BEXT = 23;
    localparam int SH1ADD = 22, SH2ADD = 21, SH3ADD = 20, ZBA = 19;
    localparam int LAND = 18, LOR = 17, LXOR = 16, SLL = 15, SRL = 14, SRA = 13;
    localparam int BEQ = 12, BNE = 11, BLT = 10, BGE = 9, ADD = 8, SUB = 7;
    localparam int SLT = 6, UNSIGN = 5, JAL = 4, PREDICT_T = 3, PREDICT_NT = 2;
    localparam int CSR_WRITE = 1, CSR_IMM = 0;

    logic        clk = 1'b0;
    logic        rstL;
    logic        scan_mode;
    logic        valid_in;
    logic [41:0] ap;
    logic        csr_ren;
    logic [31:0] csr_rdata;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result_ff;
    logic        error;

    int          vector_count = 0;
    int          miscompares  = 0;
    logic [31:0] exp_result;
    logic        exp_error;

    bmu_modport dut (
        .clk        (clk),
        .rstL       (rstL),
        .scanMode   (scan_mode),
        .validIn    (valid_in),
        .ap         (ap),
        .csrRenIn   (csr_ren),
        .csrRdataIn (csr_rdata),
        .aIn        (a_in),
        .bIn        (b_in),
        .resultFf   (result_ff),
        .error      (error)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] bitOf(input int idx);
        logic [41:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Operation-level reference: returns {error, result}.
    function automatic logic [32:0] model(input logic [41:0] p, input logic ren,
                                          input logic [31:0] rd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [41:0] s;
        int          n;
        int          sh;
        logic        lt;
        logic [31:0] r;
        logic [63:0] aa;
        logic        acc;
        s = p;
        s[ZBB] = 0; s[ZBA] = 0; s[UNSIGN] = 0;
        s[PREDICT_T] = 0; s[PREDICT_NT] = 0; s[CSR_IMM] = 0;
        n = $countones(s) + int'(ren);
        if (n != 1) return {1'b1, 32'd0};
        if (ren) return {1'b0, rd};
        sh = int'(b[4:0]);
        lt = p[UNSIGN] ? (a < b) : ($signed(a) < $signed(b));
        aa = {a, a};
        r = 0;
        if (p[ADD])            r = a + b;
        else if (p[SUB])       r = a - b;
        else if (p[SLT])       r = lt ? 1 : 0;
        else if (p[LAND])      r = p[ZBB] ? (a & ~b) : (a & b);
        else if (p[LOR])       r = p[ZBB] ? (a | ~b) : (a | b);
        else if (p[LXOR])      r = p[ZBB] ? ~(a ^ b) : (a ^ b);
        else if (p[SLL])       r = a << sh;
        else if (p[SRL])       r = a >> sh;
        else if (p[SRA]) begin
            r = a >> sh;
            if (a[31]) for (int i = 0; i < sh; i++) r[31 - i] = 1'b1;
        end
        else if (p[ROL])       r = 32'((aa << sh) >> 32);
        else if (p[ROR])       r = 32'(aa >> sh);
        else if (p[SH1ADD] || p[SH2ADD] || p[SH3ADD]) begin
            if (!p[ZBA]) return {1'b1, 32'd0};
            r = a * (p[SH1ADD] ? 2 : p[SH2ADD] ? 4 : 8) + b;
        end
        else if (p[CLZ])       begin for (int i = 31; i >= 0 && !a[i]; i--) r++; end
        else if (p[CTZ])       begin for (int i = 0; i < 32 && !a[i]; i++) r++; end
        else if (p[CPOP])      r = $countones(a);
        else if (p[SIEXT_B])   r = a[7]  ? (a | 32'hFFFF_FF00) : (a & 32'h0000_00FF);
        else if (p[SIEXT_H])   r = a[15] ? (a | 32'hFFFF_0000) : (a & 32'h0000_FFFF);
        else if (p[MIN])       r = lt ? a : b;
        else if (p[MAX])       r = lt ? b : a;
        else if (p[PACK])      r = (b << 16) | (a & 32'hFFFF);
        else if (p[PACKU])     r = (b & 32'hFFFF_0000) | (a >> 16);
        else if (p[PACKH])     r = ((b & 32'hFF) << 8) | (a & 32'hFF);
        else if (p[BSET])      begin r = a; r[sh] = 1'b1; end
        else if (p[BCLR])      begin r = a; r[sh] = 1'b0; end
        else if (p[BINV])      begin r = a; r[sh] = ~a[sh]; end
        else if (p[BEXT])      r = a[sh] ? 1 : 0;
        else if (p[BEQ])       r = (a == b) ? 1 : 0;
        else if (p[BNE])       r = (a != b) ? 1 : 0;
        else if (p[BLT])       r = lt ? 1 : 0;
        else if (p[BGE])       r = lt ? 0 : 1;
        else if (p[JAL])       r = a + 4;
        else if (p[CSR_WRITE]) r = p[CSR_IMM] ? b : a;
        else if (p[GREV]) begin
`ifdef BMU_ZBP_EN
            for (int i = 0; i < 32; i++) r[i ^ sh] = a[i];
`else
            return {1'b1, 32'd0};
`endif
        end
        else if (p[GORC]) begin
`ifdef BMU_ZBP_EN
            for (int i = 0; i < 32; i++) begin
                acc = 1'b0;
                for (int m = 0; m < 32; m++)
                    if ((m & ~sh) == 0) acc = acc | a[i ^ m];
                r[i] = acc;
            end
`else
            return {1'b1, 32'd0};
`endif
        end
        return {1'b0, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [41:0] p,
                                 input logic ren, input logic [31:0] rd,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        valid_in  = v;
        ap        = p;
        csr_ren   = ren;
        csr_rdata = rd;
        a_in      = a;
        b_in      = b;
        m = model(p, ren, rd, a, b);
        @(posedge clk);
        #1;
        if (v) begin
            exp_error  = m[32];
            exp_result = m[31:0];
        end else begin
            exp_error = 1'b0;
        end
        checkOutput({tag, "_result"}, result_ff, exp_result);
        checkOutput({tag, "_error"}, {31'b0, error}, {31'b0, exp_error});
    endtask

    int sel_ops[$] = '{CLZ, CTZ, CPOP, SIEXT_B, SIEXT_H, MIN, MAX, PACK, PACKU, PACKH,
                       ROL, ROR, GREV, GORC, BSET, BCLR, BINV, BEXT, SH1ADD, SH2ADD,
                       SH3ADD, LAND, LOR, LXOR, SLL, SRL, SRA, BEQ, BNE, BLT, BGE,
                       ADD, SUB, SLT, JAL, CSR_WRITE, -1};

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            3:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [41:0] p;
        logic        ren;
        logic        v;
        int          k;
        scan_mode = 1'b0;
        rstL      = 1'b0;
        valid_in  = 1'b1;
        ap        = bitOf(ADD);
        csr_ren   = 1'b0;
        csr_rdata = 32'h1234_5678;
        a_in      = 32'd7;
        b_in      = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", result_ff, 32'd0);
        checkOutput("reset_error", {31'b0, error}, 32'd0);
        exp_result = 32'd0;
        exp_error  = 1'b0;
        rstL = 1'b1;

        applyStimulus("idle_after_reset", 1'b0, bitOf(ADD), 1'b0, 0, 32'd3, 32'd4);
        applyStimulus("add_wrap", 1'b1, bitOf(ADD), 1'b0, 0, 32'hFFFF_FFFF, 32'd1);
        checkOutput("add_wrap_const", result_ff, 32'h0);
        applyStimulus("add_small", 1'b1, bitOf(ADD), 1'b0, 0, 32'd2, 32'd3);
        applyStimulus("hold", 1'b0, bitOf(SUB), 1'b0, 0, 32'd9, 32'd1);
        checkOutput("hold_const", result_ff, 32'd5);
        applyStimulus("sub", 1'b1, bitOf(SUB), 1'b0, 0, 32'd5, 32'd7);
        checkOutput("sub_const", result_ff, 32'hFFFF_FFFE);
        applyStimulus("slt", 1'b1, bitOf(SLT), 1'b0, 0, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_const", result_ff, 32'd1);
        applyStimulus("sltu", 1'b1, bitOf(SLT) | bitOf(UNSIGN), 1'b0, 0, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_const", result_ff, 32'd0);
        applyStimulus("clz", 1'b1, bitOf(CLZ), 1'b0, 0, 32'h0001_0000, 0);
        checkOutput("clz_const", result_ff, 32'd15);
        applyStimulus("ctz", 1'b1, bitOf(CTZ), 1'b0, 0, 32'h0001_0000, 0);
        checkOutput("ctz_const", result_ff, 32'd16);
        applyStimulus("cpop", 1'b1, bitOf(CPOP), 1'b0, 0, 32'hF0F0_F0F0, 0);
        checkOutput("cpop_const", result_ff, 32'd16);
        applyStimulus("clz_zero", 1'b1, bitOf(CLZ), 1'b0, 0, 32'd0, 0);
        checkOutput("clz_zero_const", result_ff, 32'd32);
        applyStimulus("sra", 1'b1, bitOf(SRA), 1'b0, 0, 32'h8000_0000, 32'd4);
        checkOutput("sra_const", result_ff, 32'hF800_0000);
        applyStimulus("rol", 1'b1, bitOf(ROL), 1'b0, 0, 32'h8000_0001, 32'd1);
        checkOutput("rol_const", result_ff, 32'h0000_0003);
        applyStimulus("sh2add", 1'b1, bitOf(SH2ADD) | bitOf(ZBA), 1'b0, 0, 32'd3, 32'd1);
        checkOutput("sh2add_const", result_ff, 32'd13);
        applyStimulus("sh2add_nozba", 1'b1, bitOf(SH2ADD), 1'b0, 0, 32'd3, 32'd1);
        applyStimulus("bext", 1'b1, bitOf(BEXT), 1'b0, 0, 32'h8, 32'd3);
        checkOutput("bext_const", result_ff, 32'd1);
        applyStimulus("two_sel", 1'b1, bitOf(ADD) | bitOf(SUB), 1'b0, 0, 32'd3, 32'd1);
        checkOutput("two_sel_err", {31'b0, error}, 32'd1);
        applyStimulus("csr_read", 1'b1, '0, 1'b1, 32'hDEAD_BEEF, 32'd3, 32'd1);
        checkOutput("csr_read_const", result_ff, 32'hDEAD_BEEF);
        applyStimulus("no_sel", 1'b1, bitOf(ZBB), 1'b0, 0, 32'd3, 32'd1);
        applyStimulus("grev", 1'b1, bitOf(GREV), 1'b0, 0, 32'h1, 32'd31);
`ifdef BMU_ZBP_EN
        checkOutput("grev_const", result_ff, 32'h8000_0000);
`else
        checkOutput("grev_off_err", {31'b0, error}, 32'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            p   = '0;
            ren = 1'b0;
            k   = sel_ops[$urandom_range(0, sel_ops.size() - 1)];
            if (k < 0) ren = 1'b1;
            else p[k] = 1'b1;
            p[ZBB]        = 1'($urandom_range(0, 1));
            p[ZBA]        = ($urandom_range(0, 7) != 0);
            p[UNSIGN]     = 1'($urandom_range(0, 1));
            p[PREDICT_T]  = 1'($urandom_range(0, 1));
            p[PREDICT_NT] = 1'($urandom_range(0, 1));
            p[CSR_IMM]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) p[sel_ops[$urandom_range(0, sel_ops.size() - 2)]] = 1'b1;
            v = ($urandom_range(0, 15) != 0);
            applyStimulus("rand", v, p, ren, $urandom, randOperand(), randOperand());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
        $finish;
    end
endmodule

// File: doc/bmu_modport.md
Name: bmu_modport

Overview:
- Single-cycle-latency bit-manipulation and ALU execution unit.
- Executes one operation per valid cycle, selected by a one-hot operation packet `ap`: RISC-V base ALU, Zba/Zbb/Zbs/Zbp-style ops, branch compares and CSR write/read data.
- The result is registered into `resultFf`, with an `error` flag for illegal operation encodings.
- Sits in the execute stage beside the integer pipe.

Parameters:
- None. The operand width is fixed at 32.

Ports:
- clk  input  1  core clock, rising edge active
- rstL  input  1  synchronous active-low reset
- scanMode  input  1  scan/test mode; no functional effect
- validIn  input  1  operation valid this cycle
- ap  input  42  op packet. ap[41]=clz, then descending: ctz, cpop, siext_b, siext_h, min, max, pack, packu, packh, rol, ror, grev, gorc, zbb, bset, bclr, binv, bext, sh1add, sh2add, sh3add, zba, land, lor, lxor, sll, srl, sra, beq, bne, blt, bge, add, sub, slt, unsign, jal, predict_t, predict_nt, csr_write; ap[0]=csr_imm
- csrRenIn  input  1  CSR read: result is CSR data
- csrRdataIn  input  32  CSR read data
- aIn  input  32  operand A
- bIn  input  32  operand B
- resultFf  output  32  registered result
- error  output  1  registered illegal-op flag

Behaviour:
- Reset (rstL=0 at a rising edge): resultFf=0, error=0. Reset overrides validIn.
- Latency: inputs are sampled at a rising edge with validIn=1. resultFf and error update at that same edge (one-cycle latency). Back-to-back ops are allowed every cycle.
- validIn=0: resultFf holds its value; error is cleared to 0.
- Select set: every ap bit except the modifiers zbb, zba, unsign, predict_t, predict_nt, csr_imm, plus csrRenIn.
- Exactly one select bit must be set when validIn=1. Otherwise error=1 and resultFf=0.
- Shift/bit index is sh = bIn[4:0] for all shift, rotate, bit and grev/gorc ops.
- add: a+b, modulo 2^32.
- sub: a-b.
- slt: signed a<b ? 1 : 0. With unsign set it is an unsigned compare.
- land/lor/lxor: a&b, a|b, a^b. With zbb set these become a&~b, a|~b, ~(a^b).
- sll, srl, sra: shift a by sh; sra replicates a[31].
- rol/ror: rotate a by sh.
- sh1add/sh2add/sh3add: (a<<1/2/3)+b. Both zba and the shNadd bit must be set, else error.
- clz/ctz: count leading/trailing zeros of a; returns 32 for a=0.
- cpop: number of set bits in a.
- siext_b: sign-extend a[7:0]. siext_h: sign-extend a[15:0].
- min/max: signed compare, returns a or b. With unsign set the compare is unsigned.
- pack: {b[15:0],a[15:0]}. packu: {b[31:16],a[31:16]}. packh: {16'b0,b[7:0],a[7:0]}.
- bset, bclr, binv: set/clear/invert a[sh]. bext: {31'b0,a[sh]}.
- grev: generalized reverse of a by sh (stage k swaps 2^k-bit groups when sh[k]=1).
- gorc: same stages, but each stage ORs the swapped value into the result.
- beq/bne/blt/bge: result is 1 if the condition on a,b holds, else 0. blt/bge are signed unless unsign is set.
- jal: result = a+4. predict_t/predict_nt are ignored.
- csr_write: result = csr_imm ? b : a.
- csrRenIn: result = csrRdataIn.

Optional Feature:
- Macro: BMU_ZBP_EN.
- Defined: grev and gorc are implemented as specified above.
- Undefined: grev or gorc with validIn=1 gives error=1, resultFf=0, and no permutation logic is synthesized.

Test Plan:
- Hold rstL=0 for 2 edges with validIn=1 and add set → resultFf=0, error=0. After releasing reset, validIn=0 → resultFf holds, error=0.
- add: a=0xFFFFFFFF, b=1 → 0x00000000. sub: a=5, b=7 → 0xFFFFFFFE. slt: a=0xFFFFFFFF, b=1 → 1. slt+unsign with same operands → 0.
- a=0x00010000: clz → 15, ctz → 16. cpop with a=0xF0F0F0F0 → 16. clz with a=0 → 32.
- sra: a=0x80000000, b=4 → 0xF8000000. rol: a=0x80000001, b=1 → 0x00000003. sh2add+zba: a=3, b=1 → 13. bext: a=0x8, b=3 → 1.
- Both add and sub set → error=1, resultFf=0. csrRenIn with csrRdataIn=0xDEADBEEF → 0xDEADBEEF, error=0.
- With BMU_ZBP_EN: grev a=0x00000001, b=31 → 0x80000000. Without it: same stimulus → error=1, resultFf=0.
